// File: rtl/store_tank.sv
// store_tank: 16x36 long-tank main store in one recirculating delay line,
// serial read onto mib and serial write from mob, addressed by waiting for the word.
module store_tank #(
  parameter int WORDS = 16,
  parameter int WIDTH = 36,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic          mob,
  output logic          mib,
  output logic          mib_valid,
  output logic          busy,
  output logic          done,
  output logic          minor_start,
  output logic [AW-1:0] word_cnt
);
  localparam int N = WORDS * WIDTH;
  localparam int BW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, XFER = 2'd2, DONE = 2'd3;
  logic [N-1:0] line;
  logic [BW-1:0] bit_cnt;
  logic [1:0] state, state_nx;
  logic [AW-1:0] addr_q;
  logic wr_q, last, hit, xfer, in_bit;
  assign last = bit_cnt == BW'(WIDTH - 1);
  assign hit = state == WAIT && bit_cnt == '0 && word_cnt == addr_q;
  // the hit slot is already bit 0 of the transfer, before the state reaches XFER
  assign xfer = hit || state == XFER;
  assign in_bit = xfer && wr_q ? mob : line[0];
  assign mib = line[0] & xfer & ~wr_q;
  assign mib_valid = xfer & ~wr_q;
  assign busy = state == WAIT || state == XFER;
  assign done = state == DONE;
  assign minor_start = bit_cnt == '0;
  always_comb
    state_nx = state == IDLE ? (req ? WAIT : IDLE) :
               state == WAIT ? (hit ? XFER : WAIT) :
               state == XFER ? (last ? DONE : XFER) : IDLE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      line <= '0;
      bit_cnt <= '0;
      word_cnt <= '0;
      state <= IDLE;
      addr_q <= '0;
      wr_q <= 1'b0;
    end else begin
      line <= {in_bit, line[N-1:1]};
      bit_cnt <= last ? '0 : bit_cnt + 1'b1;
      if (last) word_cnt <= word_cnt + 1'b1;
      if (state == IDLE && req) begin
        addr_q <= addr;
        wr_q <= wr;
      end
      state <= state_nx;
    end
endmodule

// File: tb/tb_store_tank.sv
// tb_store_tank: randomized checks of store_tank against a word-array model with
// a free-running tank position derived from elapsed cycles.
module tb_store_tank;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, wr = 1'b0, mob = 1'b0;
  logic [3:0] addr = '0;
  logic mib, mib_valid, busy, done, minor_start;
  logic [3:0] word_cnt;
  int checks = 0, failures = 0, pos = 0;
  logic [35:0] mem [16];

  always #5 clk = ~clk;
  // position of the line head in bit times since reset
  always @(posedge clk) pos <= !rst_n ? 0 : (pos + 1) % 576;

  store_tank dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .mob(mob),
    .mib(mib), .mib_valid(mib_valid), .busy(busy), .done(done),
    .minor_start(minor_start), .word_cnt(word_cnt)
  );

  task automatic do_xfer(input logic w, input logic [3:0] a, input logic [35:0] d,
                         input bit noise, input int abort_at, output logic [35:0] rd);
    int h, busy_n, done_n, done_at, mv_n, mv_at, stray;
    bit start_ok, rd_slot;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_before_req a=%0d busy=%b done=%b required 0 0", a, busy, done);
    end
    h = 1 + ((int'(a) * 36 - pos - 1 + 1152) % 576);
    req = 1'b1; wr = w; addr = a;
    busy_n = 0; done_n = 0; done_at = -1; mv_n = 0; mv_at = -1; stray = 0;
    rd = '0; start_ok = 0;
    for (int j = 1; j <= h + 36; j++) begin
      @(negedge clk);
      rd_slot = !w && j >= h && j < h + 36;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin done_n++; if (done_at < 0) done_at = j; end
      if (mib_valid === 1'b1) begin
        if (mv_at < 0) mv_at = j;
        if (mv_n < 36) rd[mv_n] = mib;
        mv_n++;
      end
      if (!rd_slot && mib !== 1'b0) stray++;
      if (j == h) start_ok = word_cnt === a && minor_start === 1'b1;
      if (abort_at >= 0 && j == h + abort_at + 1) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mib_valid !== 1'b0 || done_n != 0 ||
            word_cnt !== 4'd0 || minor_start !== 1'b1) begin
          failures++;
          $display("FAIL abort_state busy=%b done=%b mib_valid=%b dones=%0d word_cnt=%0d minor_start=%b required 0 0 0 0 0 1",
                   busy, done, mib_valid, done_n, word_cnt, minor_start);
        end
        rst_n = 1'b1;
        foreach (mem[i]) mem[i] = '0;
        return;
      end
      req = noise ? 1'($urandom) : 1'b0;
      if (noise) begin wr = 1'($urandom); addr = 4'($urandom); end
      if (noise && j == h + 36) req = 1'b1;
      mob = (w && j >= h && j < h + 36) ? d[j-h] : 1'b0;
      if (abort_at >= 0 && j == h + abort_at) begin rst_n = 1'b0; req = 1'b0; end
    end
    checks++;
    if (busy_n != h + 35) begin
      failures++;
      $display("FAIL busy_len a=%0d w=%b got=%0d required=%0d", a, w, busy_n, h + 35);
    end
    checks++;
    if (done_at != h + 36 || done_n != 1) begin
      failures++;
      $display("FAIL done_timing a=%0d w=%b at=%0d count=%0d required at=%0d count=1", a, w, done_at, done_n, h + 36);
    end
    checks++;
    if (!start_ok) begin
      failures++;
      $display("FAIL xfer_start a=%0d word_cnt/minor_start at slot %0d not %0d/1", a, h, a);
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL mib_quiet a=%0d w=%b stray_ones=%0d required 0", a, w, stray);
    end
    checks++;
    if (w ? mv_n != 0 : (mv_at != h || mv_n != 36)) begin
      failures++;
      $display("FAIL mib_valid a=%0d w=%b first=%0d count=%0d required first=%0d count=%0d",
               a, w, mv_at, mv_n, w ? -1 : h, w ? 0 : 36);
    end
    if (!w) begin
      checks++;
      if (rd !== mem[a]) begin
        failures++;
        $display("FAIL read_data a=%0d got=%h required=%h", a, rd, mem[a]);
      end
    end else mem[a] = d;
    mob = 1'b0;
    if (noise) begin
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL req_in_done_ignored busy=%b done=%b required 0 0", busy, done);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    foreach (mem[i]) mem[i] = '0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mib !== 1'b0 || mib_valid !== 1'b0 ||
        minor_start !== 1'b1 || word_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset busy=%b done=%b mib=%b mib_valid=%b minor_start=%b word_cnt=%0d required 0 0 0 0 1 0",
               busy, done, mib, mib_valid, minor_start, word_cnt);
    end
  endtask

  task automatic test_counters();
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 80)) @(negedge clk);
      checks++;
      if (word_cnt !== 4'(pos / 36) || minor_start !== (pos % 36 == 0)) begin
        failures++;
        $display("FAIL counters word_cnt=%0d minor_start=%b required %0d %b",
                 word_cnt, minor_start, pos / 36, pos % 36 == 0);
      end
    end
  endtask

  task automatic test_write_read();
    logic [35:0] r;
    do_xfer(1'b1, 4'd5, 36'h9_A5A5_A5A5, 0, -1, r);
    do_xfer(1'b0, 4'd5, '0, 0, -1, r);
    do_xfer(1'b0, 4'd5, '0, 0, -1, r);
  endtask

  task automatic test_unwritten();
    logic [35:0] r;
    do_xfer(1'b0, 4'd3, '0, 0, -1, r);
  endtask

  task automatic wait_pos(input int t);
    int n = 0;
    while (pos != t && n < 600) begin @(negedge clk); n++; end
    checks++;
    if (pos != t) begin
      failures++;
      $display("FAIL wait_pos reached=%0d required=%0d", pos, t);
    end
  endtask

  task automatic test_worst_wait();
    logic [35:0] r;
    wait_pos(144);
    do_xfer(1'b0, 4'd4, '0, 1, -1, r);
  endtask

  task automatic test_wrap();
    logic [35:0] r;
    do_xfer(1'b1, 4'd15, 36'hF_FFFF_FFFF, 0, -1, r);
    do_xfer(1'b0, 4'd0, '0, 0, -1, r);
    do_xfer(1'b0, 4'd15, '0, 0, -1, r);
  endtask

  task automatic test_back_to_back();
    logic [35:0] r, d;
    logic [3:0] a;
    for (int i = 0; i < 12; i++) begin
      a = 4'($urandom);
      d = {4'($urandom), 32'($urandom)};
      do_xfer(1'($urandom), a, d, bit'($urandom_range(0, 3) == 0), -1, r);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 5)) @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    logic [35:0] r;
    do_xfer(1'b1, 4'd7, 36'h5_1234_5678, 0, 10, r);
    do_xfer(1'b0, 4'd7, '0, 0, -1, r);
    do_xfer(1'b0, 4'd5, '0, 0, -1, r);
  endtask

  initial begin
    test_reset();
    test_counters();
    test_write_read();
    test_unwritten();
    test_worst_wait();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
